serial_parity_rx: RTL and testbench
===================================

Name: serial_parity_rx

Overview:
Serial receiver/checker for the 9-bit parity path; the receiving end of the HC280-style even/odd parity generator.
- Deserialises an LSB-first frame: start bit, DATA_W data bits, parity bit, stop bit.
- Recomputes parity and flags parity and framing errors.
- Sits downstream of the parity-generator/serialiser and is clocked by the shared clk generator.

Parameters:
- DATA_W, 9: data bits per frame; legal range 1..16.
- ODD_PAR, 0: 0 selects even parity (total ones in data+parity even); 1 selects odd.

Ports:
- clk  input  1  system clock from the clk generator; all logic on rising edge.
- clr  input  1  synchronous, active-high reset.
- en  input  1  bit-sample enable; rx is consumed only on edges where en=1.
- rx  input  1  serial line; idles high.
- data_out  output  DATA_W  last received data word.
- valid  output  1  one-cycle pulse when a frame completes.
- par_err  output  1  parity mismatch on last frame; valid with valid, held until next valid.
- frm_err  output  1  stop bit sampled low on last frame; held like par_err.
- busy  output  1  high in any state other than IDLE.
- err_cnt  output  8  error counter (see Optional Feature).

Behaviour:
- Reset: clr=1 at a rising edge sets state=IDLE, bit_cnt=0, shift/parity accumulators=0, data_out=0, valid=0, par_err=0, frm_err=0, busy=0, err_cnt=0.
- clr has priority over every other event; reset mid-frame discards the partial frame with no valid pulse.
- en=0: state, counters and accumulators hold. valid still drops after one cycle and never stretches.
- IDLE: on en=1 and rx=0 (start bit), go to DATA with bit_cnt=0 and par_acc=ODD_PAR. On en=1 and rx=1, stay in IDLE.
- No start-bit revalidation: a single low sample starts a frame.
- DATA: each en=1 edge writes rx into shift[bit_cnt] (LSB first), sets par_acc ^= rx and increments bit_cnt.
  - After the sample with bit_cnt==DATA_W-1, go to PARITY.
- PARITY: on en=1, set par_bad = par_acc ^ rx, then go to STOP.
  - Even mode: error iff data ones + parity bit is odd.
- STOP: on the en=1 edge:
  - data_out <= shift, par_err <= par_bad, frm_err <= ~rx, valid <= 1; go to IDLE.
  - valid is asserted even when par_err or frm_err is set.
- Latency: valid rises in the cycle after the stop-sample edge, which is DATA_W+3 enabled samples after the start sample. With en tied high and DATA_W=9, valid rises 12 clocks after the start-sample edge.
- Back-to-back frames: IDLE may accept a new start bit on the first en edge after the stop sample.
  - data_out, par_err and frm_err change only on the next valid.
- frm_err frames are not resynchronised. The receiver returns to IDLE and waits for rx=0.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: SERIAL_PARITY_RX_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each valid pulse where par_err or frm_err is set.
  - Saturates at 8'hFF; does not wrap.
  - Cleared only by clr.
- Undefined: err_cnt is tied to 8'h00 and no counter flops are built.
- The port list is identical in both builds.

Decomposition:
- Shared package/include (serial_parity_defs):
  - State encoding localparams: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - Default DATA_W=9.
  - Parity-mode constants PAR_EVEN=0, PAR_ODD=1.
- One sub-module, parity_accum: a bit counter plus parity accumulator flop with load/step/clear controls, shared with the transmitter side.
- The FSM, shift register and output registers stay in the top module.

Test Plan:
- Nominal even, en=1 continuous, DATA_W=9, ODD_PAR=0: drive 0, data 9'h0A5 LSB first (1,0,1,0,0,1,0,1,0), parity 0, stop 1 -> valid pulses 1 cycle, 12 clocks after start sample; data_out=9'h0A5, par_err=0, frm_err=0, busy low afterwards.
- Parity error: same frame with parity bit 1 -> valid=1, data_out=9'h0A5, par_err=1, frm_err=0; err_cnt=1 with SERIAL_PARITY_RX_ERRCNT_EN, 0 without.
- Framing error plus odd mode (ODD_PAR=1): data 9'h1FF (9 ones), parity 0, stop 0 -> valid=1, par_err=0, frm_err=1.
- en gating and back-to-back: en toggled 1/0 every other clock across two consecutive frames 9'h001 (parity 1) and 9'h100 (parity 1), with no idle gap -> two valid pulses; data_out=9'h001 then 9'h100; all error flags 0; state frozen on en=0 cycles.
- Reset mid-frame: clr=1 after 4 data bits, then a clean frame 9'h0F0 (parity 0) -> no valid for the aborted frame; all outputs 0 after clr; next frame gives data_out=9'h0F0 with no errors.
- Saturation (macro defined): 260 consecutive parity-error frames -> err_cnt reaches 8'hFF and stays at 8'hFF.

Source files
------------

// File: rtl/serial_parity_defs.sv
// ---------------------------------------------------------------------------
// serial_parity_defs
// Shared definitions for the serial parity path (receiver and transmitter).
//   state_t    : FSM state encoding (IDLE/DATA/PARITY/STOP)
//   DATA_W_DEF : default number of data bits per frame
//   PAR_EVEN / PAR_ODD : parity-mode selectors
//   cnt_width  : width of a bit counter able to hold 0..n
// ---------------------------------------------------------------------------
package serial_parity_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 9;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // The counter steps once past the last data index before the FSM leaves
  // DATA, so it is sized to hold n itself.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_parity_rx_parity_accum.sv
// ---------------------------------------------------------------------------
// parity_accum
// Bit counter plus running-parity flop, shared by the serial transmitter and
// receiver.
// Ports:
//   clk        : system clock, rising edge
//   i_clr      : synchronous active-high clear (count=0, parity=0)
//   i_load     : restart: count=0, parity=i_load_par
//   i_load_par : parity seed applied on i_load (selects even/odd sense)
//   i_step     : count+1, parity ^= i_bit
//   i_bit      : bit folded into the parity on i_step
//   o_cnt      : current bit count
//   o_par      : running parity
// Priority: clear > load > step.
// ---------------------------------------------------------------------------
module parity_accum #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_load_par,
  input  logic             i_step,
  input  logic             i_bit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_par
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_par;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_par <= i_load_par;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      r_par <= r_par ^ i_bit;
    end
  end

  assign o_cnt = r_cnt;
  assign o_par = r_par;

endmodule

// File: rtl/serial_parity_rx.sv
// ---------------------------------------------------------------------------
// serial_parity_rx
// Serial receiver/checker for the parity path. Deserialises an LSB-first
// frame (start bit, DATA_W data bits, parity bit, stop bit) sampled on
// en=1 edges, recomputes parity and flags parity and framing errors.
// Ports:
//   clk      : system clock, rising edge
//   clr      : synchronous active-high reset, highest priority
//   en       : bit-sample enable; rx consumed only when en=1
//   rx       : serial line, idles high
//   data_out : last received data word (updates with valid)
//   valid    : one-cycle pulse when a frame completes
//   par_err  : parity mismatch on last frame, held until next valid
//   frm_err  : stop bit sampled low on last frame, held until next valid
//   busy     : high whenever the FSM is not in IDLE
//   err_cnt  : saturating count of errored frames
// Build option: define SERIAL_PARITY_RX_ERRCNT_EN to build the error
// counter; otherwise err_cnt is constant zero. Port list is identical.
// ---------------------------------------------------------------------------
module serial_parity_rx
  import serial_parity_defs::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ODD_PAR = PAR_EVEN
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  // Seeding the accumulator with 1 turns the even-parity check into an odd one.
  localparam logic             PAR_SEED = (ODD_PAR != 0);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_par_err;
  logic              r_frm_err;
  logic              r_busy;
  logic              r_par_bad;

  logic [CNT_W-1:0]  w_bit_cnt;
  logic              w_par_acc;
  logic              w_load;
  logic              w_step;
  logic              w_stop;
  logic [DATA_W-1:0] w_hit;

  assign w_load = en && (r_state == IDLE) && !rx;
  assign w_step = en && (r_state == DATA);
  assign w_stop = en && (r_state == STOP);

  parity_accum #(
    .CNT_W (CNT_W)
  ) u_accum (
    .clk        (clk),
    .i_clr      (clr),
    .i_load     (w_load),
    .i_load_par (PAR_SEED),
    .i_step     (w_step),
    .i_bit      (rx),
    .o_cnt      (w_bit_cnt),
    .o_par      (w_par_acc)
  );

  // One-hot decode of the bit counter: selects which shift bit takes rx.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_hit
    assign w_hit[gi] = (w_bit_cnt == CNT_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_busy    <= 1'b0;
      r_par_bad <= 1'b0;
    end else begin
      // valid is a strict one-cycle pulse regardless of en.
      r_valid <= 1'b0;
      if (en) begin
        case (r_state)
          IDLE: begin
            if (!rx) begin
              r_state <= DATA;
              r_busy  <= 1'b1;
            end
          end
          DATA: begin
            for (int i = 0; i < DATA_W; i++) begin
              if (w_hit[i]) r_shift[i] <= rx;
            end
            if (w_bit_cnt == LAST_IDX) r_state <= PARITY;
          end
          PARITY: begin
            r_par_bad <= w_par_acc ^ rx;
            r_state   <= STOP;
          end
          STOP: begin
            r_data    <= r_shift;
            r_par_err <= r_par_bad;
            r_frm_err <= ~rx;
            r_valid   <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign par_err  = r_par_err;
  assign frm_err  = r_frm_err;
  assign busy     = r_busy;

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Counted on the stop-sample edge so err_cnt moves together with valid.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_err_cnt <= 8'h00;
    end else if (w_stop && (r_par_bad || !rx) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_parity_rx
// Directed plus randomized frames into an even-parity and an odd-parity
// receiver (DATA_W=9). Expected words/flags come from a frame-level model
// (popcount parity, stop-bit value, saturating error tally).
// ---------------------------------------------------------------------------
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       clr, en, rx_e, rx_o;
  logic [8:0] data_out_e, data_out_o;
  logic       valid_e, valid_o, par_err_e, par_err_o, frm_err_e, frm_err_o;
  logic       busy_e, busy_o;
  logic [7:0] err_cnt_e, err_cnt_o;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(9), .ODD_PAR(0)) dut_e (
    .clk(clk), .clr(clr), .en(en), .rx(rx_e),
    .data_out(data_out_e), .valid(valid_e), .par_err(par_err_e),
    .frm_err(frm_err_e), .busy(busy_e), .err_cnt(err_cnt_e)
  );

  serial_parity_rx #(.DATA_W(9), .ODD_PAR(1)) dut_o (
    .clk(clk), .clr(clr), .en(en), .rx(rx_o),
    .data_out(data_out_o), .valid(valid_o), .par_err(par_err_o),
    .frm_err(frm_err_o), .busy(busy_o), .err_cnt(err_cnt_o)
  );

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int exp_err [2];
  logic [10:0] q_e[$];
  logic [10:0] q_o[$];
  bit prev_v_e = 1'b0;
  bit prev_v_o = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture every completed frame; a valid seen on two negedges in a row
  // would be a stretched pulse.
  always @(negedge clk) begin
    if (valid_e === 1'b1) begin
      chk("valid_e_pulse_width", 32'(prev_v_e), 32'd0);
      q_e.push_back({par_err_e, frm_err_e, data_out_e});
    end
    if (valid_o === 1'b1) begin
      chk("valid_o_pulse_width", 32'(prev_v_o), 32'd0);
      q_o.push_back({par_err_o, frm_err_o, data_out_o});
    end
    prev_v_e = (valid_e === 1'b1);
    prev_v_o = (valid_o === 1'b1);
  end

  task automatic set_rx(input bit sel, input bit b);
    if (sel) rx_o = b;
    else     rx_e = b;
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? busy_o : busy_e;
  endfunction

  // Optional en=0 cycle with a random rx value that must be ignored.
  task automatic drive_bit(input bit sel, input bit b, input bit gated);
    logic bb;
    if (gated) begin
      @(negedge clk);
      en = 1'b0;
      set_rx(sel, 1'($urandom % 2));
      bb = get_busy(sel);
      @(posedge clk);
      #1;
      chk("hold_busy_en0", 32'(get_busy(sel)), 32'(bb));
    end
    @(negedge clk);
    en = 1'b1;
    set_rx(sel, b);
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] d, input bit p,
                            input bit s, input bit gated);
    drive_bit(sel, 1'b0, gated);
    for (int i = 0; i < 9; i++) drive_bit(sel, d[i], gated);
    drive_bit(sel, p, gated);
    drive_bit(sel, s, gated);
  endtask

  // Frame-level reference: parity over data ones plus parity bit.
  task automatic expect_frame(input bit sel, input logic [8:0] d, input bit p,
                              input bit s, input string tag);
    bit pe, fe;
    int n;
    logic [10:0] got;
    pe = ((($countones(d) + int'(p) + int'(sel)) % 2) != 0);
    fe = !s;
    if (ERRCNT_ON && (pe || fe) && exp_err[sel] < 255) exp_err[sel]++;
    n = 0;
    do begin
      @(negedge clk);
      rx_e = 1'b1;
      rx_o = 1'b1;
      en   = 1'b1;
      #1;
      n++;
    end while ((sel ? q_o.size() : q_e.size()) == 0 && n < 40);
    checks++;
    assert ((sel ? q_o.size() : q_e.size()) != 0)
    else begin
      errors++;
      $error("FAIL %s_timeout: observed=no valid expected=valid within 40 cycles", tag);
    end
    if ((sel ? q_o.size() : q_e.size()) != 0) begin
      got = sel ? q_o.pop_front() : q_e.pop_front();
      chk({tag, "_data"},    32'(got[8:0]), 32'(d));
      chk({tag, "_par_err"}, 32'(got[10]),  32'(pe));
      chk({tag, "_frm_err"}, 32'(got[9]),   32'(fe));
    end
  endtask

  task automatic check_errcnt(input bit sel, input string tag);
    chk({tag, "_err_cnt"}, 32'(sel ? err_cnt_o : err_cnt_e), 32'(exp_err[sel]));
  endtask

  initial begin
    logic [8:0] d;
    bit p, s, g, sel;

    exp_err[0] = 0;
    exp_err[1] = 0;
    clr  = 1'b1;
    en   = 1'b0;
    rx_e = 1'b1;
    rx_o = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_e",  32'(data_out_e), 32'd0);
    chk("rst_valid_e", 32'(valid_e),    32'd0);
    chk("rst_perr_e",  32'(par_err_e),  32'd0);
    chk("rst_ferr_e",  32'(frm_err_e),  32'd0);
    chk("rst_busy_e",  32'(busy_e),     32'd0);
    chk("rst_cnt_e",   32'(err_cnt_e),  32'd0);
    chk("rst_busy_o",  32'(busy_o),     32'd0);
    clr = 1'b0;

    // Nominal even frame with latency check around the stop sample.
    send_frame(1'b0, 9'h0A5, 1'b0, 1'b1, 1'b0);
    chk("nom_valid_before_stop", 32'(valid_e), 32'd0);
    @(posedge clk);
    #1;
    chk("nom_valid_after_stop", 32'(valid_e), 32'd1);
    expect_frame(1'b0, 9'h0A5, 1'b0, 1'b1, "nominal");
    chk("nom_busy_after", 32'(busy_e), 32'd0);
    check_errcnt(1'b0, "nominal");

    // Parity error.
    send_frame(1'b0, 9'h0A5, 1'b1, 1'b1, 1'b0);
    expect_frame(1'b0, 9'h0A5, 1'b1, 1'b1, "parerr");
    check_errcnt(1'b0, "parerr");

    // Framing error in odd mode.
    send_frame(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);
    expect_frame(1'b1, 9'h1FF, 1'b0, 1'b0, "odd_frm");
    check_errcnt(1'b1, "odd_frm");

    // en gating with back-to-back frames.
    send_frame(1'b0, 9'h001, 1'b1, 1'b1, 1'b1);
    send_frame(1'b0, 9'h100, 1'b1, 1'b1, 1'b1);
    expect_frame(1'b0, 9'h001, 1'b1, 1'b1, "b2b_first");
    expect_frame(1'b0, 9'h100, 1'b1, 1'b1, "b2b_second");
    chk("b2b_busy_after", 32'(busy_e), 32'd0);

    // Reset in the middle of a frame.
    drive_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'($urandom % 2), 1'b0);
    @(negedge clk);
    clr  = 1'b1;
    rx_e = 1'b1;
    en   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_err[0] = 0;
    exp_err[1] = 0;
    chk("midrst_data",  32'(data_out_e), 32'd0);
    chk("midrst_valid", 32'(valid_e),    32'd0);
    chk("midrst_perr",  32'(par_err_e),  32'd0);
    chk("midrst_ferr",  32'(frm_err_e),  32'd0);
    chk("midrst_busy",  32'(busy_e),     32'd0);
    chk("midrst_cnt_e", 32'(err_cnt_e),  32'd0);
    chk("midrst_cnt_o", 32'(err_cnt_o),  32'd0);
    repeat (14) @(negedge clk);
    chk("midrst_no_valid", 32'(q_e.size()), 32'd0);
    send_frame(1'b0, 9'h0F0, 1'b0, 1'b1, 1'b0);
    expect_frame(1'b0, 9'h0F0, 1'b0, 1'b1, "post_rst");
    check_errcnt(1'b0, "post_rst");

    // Randomized frames on both receivers.
    for (int k = 0; k < 24; k++) begin
      sel = 1'($urandom % 2);
      d   = 9'($urandom);
      p   = 1'($urandom % 2);
      s   = ($urandom % 4) != 0;
      g   = 1'($urandom % 2);
      send_frame(sel, d, p, s, g);
      expect_frame(sel, d, p, s, "rand");
      check_errcnt(sel, "rand");
    end

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    // Drive the counter past 8'hFF: every frame carries the wrong parity.
    for (int k = 0; k < 260; k++) begin
      d = 9'($urandom);
      p = ~(^d);
      send_frame(1'b0, d, p, 1'b1, 1'b0);
      expect_frame(1'b0, d, p, 1'b1, "sat");
      check_errcnt(1'b0, "sat");
    end
    chk("sat_final", 32'(err_cnt_e), 32'hFF);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
